rf80386_prefetch_queue: RTL and testbench

Parametrised instruction prefetch/byte-alignment queue that sits between the instruction cache port (ibundle/ihit) and the rf80386 decoder. It replaces the single 128-bit bundle shift register with a circular byte queue several bundles deep. The queue presents a byte-aligned decode window and lets the decoder consume a variable number of bytes per cycle. It generates aligned fetch addresses and handles flushes on branch, interrupt and far transfer.

---
 rtl/rf80386_prefetch_queue.sv | 135 +++++++++++++
 tb/tb_rf80386_prefetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf80386_prefetch_queue.sv
// Prefetch/byte-alignment queue between the icache bundle port and the decoder.
// Latency: accepted bundle bytes show in win_o the cycle after the accepting edge.
// Backpressure: fetch_req_o drops when fewer than BUNDLE_BYTES bytes are free.
// Optional build macro RF80386_PQ_NOP_FILL_EN: pad invalid win_o bytes with 8'h90 instead of 8'h00.
module rf80386_prefetch_queue #(
  parameter int unsigned BUNDLE_BYTES  = 16,
  parameter int unsigned DEPTH_BUNDLES = 2,
  parameter int unsigned WIN_BYTES     = 16,
  parameter logic [31:0] RESET_ADR     = 32'hFFFF0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [31:0]                    flush_adr_i,
  output logic                           fetch_req_o,
  output logic [31:0]                    fetch_adr_o,
  input  logic                           ihit_i,
  input  logic [8*BUNDLE_BYTES-1:0]      ibundle_i,
  output logic [8*WIN_BYTES-1:0]         win_o,
  output logic [$clog2(WIN_BYTES+1)-1:0] win_cnt_o,
  input  logic [$clog2(WIN_BYTES+1)-1:0] consume_i,
  output logic [31:0]                    eip_o,
  output logic                           overrun_o,
  output logic                           empty_o,
  output logic                           full_o
);

  localparam int unsigned QBYTES = BUNDLE_BYTES * DEPTH_BUNDLES;
  localparam int unsigned PW     = $clog2(QBYTES);
  localparam int unsigned CW     = $clog2(QBYTES + 1);
  localparam int unsigned WCW    = $clog2(WIN_BYTES + 1);
  localparam int unsigned OW     = $clog2(BUNDLE_BYTES);
  localparam logic [31:0] ALIGN_MASK = ~(32'(BUNDLE_BYTES) - 32'd1);
`ifdef RF80386_PQ_NOP_FILL_EN
  localparam logic [7:0] FILL_BYTE = 8'h90;
`else
  localparam logic [7:0] FILL_BYTE = 8'h00;
`endif

  typedef enum logic {ST_FIRST, ST_STEADY} state_t;

  logic [7:0]    r_mem [QBYTES];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_eip;
  logic [31:0]   r_fetch_adr;
  logic          r_fetch_req;
  logic          r_overrun;
  state_t        r_state;

  logic [WCW-1:0] w_win_cnt;
  logic           w_overrun;
  logic [WCW-1:0] w_eff;
  logic           w_accept;
  logic [OW-1:0]  w_skip;
  logic [CW-1:0]  w_added;
  logic [CW-1:0]  w_count_nxt;
  logic           w_req_nxt;

  // Window occupancy, consume clamping, bundle acceptance and next-state count.
  always_comb begin
    w_win_cnt = (r_count > CW'(WIN_BYTES)) ? WCW'(WIN_BYTES) : WCW'(r_count);
    w_overrun = consume_i > w_win_cnt;
    w_eff     = w_overrun ? w_win_cnt : consume_i;
    w_accept  = r_fetch_req && ihit_i && !flush_i;
    // Only the first bundle after a restart is trimmed to the eip byte offset.
    w_skip    = (r_state == ST_FIRST) ? r_eip[OW-1:0] : '0;
    w_added   = w_accept ? (CW'(BUNDLE_BYTES) - CW'(w_skip)) : '0;
    w_count_nxt = flush_i ? '0 : (r_count - CW'(w_eff) + w_added);
    w_req_nxt = !flush_i && ((CW'(QBYTES) - w_count_nxt) >= CW'(BUNDLE_BYTES));
  end

  // Byte storage: pack the kept bundle bytes contiguously from the write pointer.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      for (int i = 0; i < BUNDLE_BYTES; i++) begin
        if (i >= int'(w_skip)) begin
          r_mem[PW'(r_wr_ptr + PW'(i) - PW'(w_skip))] <= ibundle_i[8*i +: 8];
        end
      end
    end
  end

  // Control state: pointers, count, addresses, fetch request and overrun pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_eip       <= RESET_ADR;
      r_fetch_adr <= RESET_ADR & ALIGN_MASK;
      r_fetch_req <= 1'b0;
      r_overrun   <= 1'b0;
      r_state     <= ST_FIRST;
    end else if (flush_i) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_eip       <= flush_adr_i;
      r_fetch_adr <= flush_adr_i & ALIGN_MASK;
      r_fetch_req <= 1'b0;
      r_overrun   <= 1'b0;
      r_state     <= ST_FIRST;
    end else begin
      r_rd_ptr    <= r_rd_ptr + PW'(w_eff);
      r_wr_ptr    <= r_wr_ptr + PW'(w_added);
      r_count     <= w_count_nxt;
      r_eip       <= r_eip + 32'(w_eff);
      r_fetch_req <= w_req_nxt;
      r_overrun   <= w_overrun;
      if (w_accept) begin
        r_fetch_adr <= r_fetch_adr + 32'(BUNDLE_BYTES);
        r_state     <= ST_STEADY;
      end
    end
  end

  // Decode window: bytes from the read pointer, wrapping mod QBYTES, padded past win_cnt.
  always_comb begin
    win_o = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      win_o[8*i +: 8] = (i < int'(w_win_cnt)) ? r_mem[PW'(r_rd_ptr + PW'(i))] : FILL_BYTE;
    end
  end

  assign fetch_req_o = r_fetch_req;
  assign fetch_adr_o = r_fetch_adr;
  assign win_cnt_o   = w_win_cnt;
  assign eip_o       = r_eip;
  assign overrun_o   = r_overrun;
  assign empty_o     = (r_count == '0);
  assign full_o      = (CW'(QBYTES) - r_count) < CW'(BUNDLE_BYTES);

endmodule

// File: tb/tb_rf80386_prefetch_queue.sv
// Self-checking bench for rf80386_prefetch_queue (default parameters).
// A byte-queue model tracks the expected window; outputs are compared every negedge.
module tb_rf80386_prefetch_queue;
  localparam int BB = 16;
  localparam int WB = 16;
  localparam int QB = 32;
`ifdef RF80386_PQ_NOP_FILL_EN
  localparam logic [7:0] FILL = 8'h90;
`else
  localparam logic [7:0] FILL = 8'h00;
`endif

  logic         clk = 1'b0;
  logic         rst_ni = 1'b1;
  logic         flush_i = 1'b0;
  logic [31:0]  flush_adr_i = '0;
  logic         fetch_req_o;
  logic [31:0]  fetch_adr_o;
  logic         ihit_i = 1'b0;
  logic [127:0] ibundle_i = '0;
  logic [127:0] win_o;
  logic [4:0]   win_cnt_o;
  logic [4:0]   consume_i = '0;
  logic [31:0]  eip_o;
  logic         overrun_o;
  logic         empty_o;
  logic         full_o;

  rf80386_prefetch_queue dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_adr_i(flush_adr_i),
    .fetch_req_o(fetch_req_o), .fetch_adr_o(fetch_adr_o), .ihit_i(ihit_i),
    .ibundle_i(ibundle_i), .win_o(win_o), .win_cnt_o(win_cnt_o), .consume_i(consume_i),
    .eip_o(eip_o), .overrun_o(overrun_o), .empty_o(empty_o), .full_o(full_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the queue is literally a list of byte values in address order.
  logic [7:0]  mq[$];
  logic [31:0] m_eip;
  logic [31:0] m_fadr;
  bit          m_first;
  bit          m_req;
  bit          m_ovr;
  bit          chk_en = 1'b0;

  task automatic model_reset();
    mq.delete();
    m_eip   = 32'hFFFF0000;
    m_fadr  = 32'hFFFF0000;
    m_first = 1'b1;
    m_req   = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_step(input logic fl, input logic [31:0] fa, input logic hit,
                            input logic [127:0] bun, input logic [4:0] cons);
    int wc, eff, start;
    logic [31:0] old_eip;
    if (fl) begin
      mq.delete();
      m_eip   = fa;
      m_fadr  = {fa[31:4], 4'h0};
      m_first = 1'b1;
      m_req   = 1'b0;
      m_ovr   = 1'b0;
    end else begin
      wc      = (mq.size() < WB) ? mq.size() : WB;
      m_ovr   = int'(cons) > wc;
      eff     = m_ovr ? wc : int'(cons);
      old_eip = m_eip;
      for (int k = 0; k < eff; k++) void'(mq.pop_front());
      m_eip = m_eip + 32'(eff);
      if (m_req && hit) begin
        start = m_first ? int'(old_eip[3:0]) : 0;
        for (int k = start; k < BB; k++) mq.push_back(bun[8*k +: 8]);
        m_fadr  = m_fadr + 32'd16;
        m_first = 1'b0;
      end
      m_req = (QB - mq.size()) >= BB;
    end
  endtask

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin : cmp
    logic [127:0] ew;
    int sz;
    if (chk_en) begin
      sz = mq.size();
      ew = '0;
      for (int i = 0; i < WB; i++) ew[8*i +: 8] = (i < sz) ? mq[i] : FILL;
      chk("fetch_req", fetch_req_o, m_req);
      chk("fetch_adr", fetch_adr_o, m_fadr);
      chk("eip", eip_o, m_eip);
      chk("win_cnt", win_cnt_o, (sz < WB) ? sz : WB);
      chk("win", win_o, ew);
      chk("empty", empty_o, sz == 0);
      chk("full", full_o, (QB - sz) < BB);
      chk("overrun", overrun_o, m_ovr);
    end
  end

  task automatic step(input logic fl, input logic [31:0] fa, input logic hit,
                      input logic [127:0] bun, input logic [4:0] cons);
    flush_i = fl; flush_adr_i = fa; ihit_i = hit; ibundle_i = bun; consume_i = cons;
    @(posedge clk);
    model_step(fl, fa, hit, bun, cons);
    #1;
    flush_i = 1'b0; ihit_i = 1'b0; consume_i = '0;
  endtask

  function automatic logic [127:0] seq_bundle(input logic [7:0] base);
    logic [127:0] b;
    for (int i = 0; i < BB; i++) b[8*i +: 8] = base + 8'(i);
    return b;
  endfunction

  initial begin
    logic [127:0] fillv;
    logic [127:0] wv;
    logic         fl, hit;
    logic [31:0]  fa;
    logic [4:0]   cons;
    int           r;

    #2 rst_ni = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset release: first request comes out one cycle later.
    step(0, 0, 0, '0, 0);
    chk("rst_req", fetch_req_o, 1'b1);
    chk("rst_fadr", fetch_adr_o, 32'hFFFF0000);
    chk("rst_eip", eip_o, 32'hFFFF0000);
    chk("rst_wcnt", win_cnt_o, 5'd0);
    chk("rst_empty", empty_o, 1'b1);

    // Unaligned flush: first bundle is trimmed by the eip offset.
    step(1, 32'h00001003, 0, '0, 0);
    chk("fl1_req0", fetch_req_o, 1'b0);
    step(0, 0, 0, '0, 0);
    chk("fl1_req", fetch_req_o, 1'b1);
    chk("fl1_fadr", fetch_adr_o, 32'h00001000);
    step(0, 0, 1, seq_bundle(8'h00), 0);
    chk("fl1_wcnt", win_cnt_o, 5'd13);
    chk("fl1_b0", win_o[7:0], 8'h03);
    chk("fl1_eip", eip_o, 32'h00001003);
    chk("fl1_fadr2", fetch_adr_o, 32'h00001010);

    // Aligned flush, fill to capacity, then drain one bundle.
    step(1, 32'h00002000, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, seq_bundle(8'h20), 0);
    chk("fill_req1", fetch_req_o, 1'b1);
    step(0, 0, 1, seq_bundle(8'h30), 0);
    chk("full_full", full_o, 1'b1);
    chk("full_req", fetch_req_o, 1'b0);
    step(0, 0, 1, seq_bundle(8'h99), 0);  // ihit without request must be ignored
    chk("full_wcnt", win_cnt_o, 5'd16);
    step(0, 0, 0, '0, 5'd16);
    chk("drain_req", fetch_req_o, 1'b1);
    chk("drain_eip", eip_o, 32'h00002010);
    chk("drain_b0", win_o[7:0], 8'h30);

    // Simultaneous accept and consume at count 16.
    step(0, 0, 1, seq_bundle(8'h40), 5'd5);
    chk("sim_eip", eip_o, 32'h00002015);
    chk("sim_b0", win_o[7:0], 8'h35);
    chk("sim_full", full_o, 1'b1);

    // Drain to 4 bytes, then over-consume.
    step(0, 0, 0, '0, 5'd16);
    step(0, 0, 0, '0, 5'd7);
    chk("c4_wcnt", win_cnt_o, 5'd4);
    chk("c4_b0", win_o[7:0], 8'h4C);
    step(0, 0, 0, '0, 5'd10);
    chk("ovr_pulse", overrun_o, 1'b1);
    chk("ovr_eip", eip_o, 32'h00002030);
    chk("ovr_empty", empty_o, 1'b1);
    step(0, 0, 0, '0, 0);
    chk("ovr_clear", overrun_o, 1'b0);

    // Flush coincident with ihit drops the bundle.
    step(1, 32'h00003000, 1, seq_bundle(8'h50), 0);
    chk("flhit_wcnt", win_cnt_o, 5'd0);
    chk("flhit_req", fetch_req_o, 1'b0);
    step(1, 32'h00003000, 0, '0, 0);
    chk("flhold_req", fetch_req_o, 1'b0);

    // Three valid bytes: the rest of the window is padding.
    step(1, 32'h0000400D, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, seq_bundle(8'h00), 0);
    fillv = {13{FILL}};
    wv = win_o;
    chk("pad_wcnt", win_cnt_o, 5'd3);
    chk("pad_low", wv[23:0], 24'h0F0E0D);
    chk("pad_high", wv[127:24], fillv[103:0]);

    // Address wrap of the fetch pointer.
    step(1, 32'hFFFFFFE7, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, seq_bundle(8'h60), 0);
    step(0, 0, 1, seq_bundle(8'h70), 5'd9);
    chk("wrap_fadr", fetch_adr_o, 32'h00000000);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      fl  = ($urandom_range(0, 39) == 0);
      fa  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFC0 + 32'($urandom_range(0, 63))) : $urandom;
      hit = ($urandom_range(0, 9) < 6);
      r   = $urandom_range(0, 9);
      if (r < 3)      cons = 5'd0;
      else if (r < 8) cons = 5'($urandom_range(0, 8));
      else            cons = 5'($urandom_range(0, 16));
      step(fl, fa, hit, {$urandom, $urandom, $urandom, $urandom}, cons);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
